instr_decode: RTL and testbench

Pipelined instruction-decode stage for the 32-bit MIPS-style core. It accepts one 32-bit instruction per handshake and splits it into the register-file read/write addresses (`readReg1`, `readReg2`, `writeReg`). It also produces the sign- or zero-extended immediate and the datapath control bits, all held in a single output pipeline register. It sits directly upstream of `registers`. With `DECODE_HAZARD_EN` compiled in, it inserts a one-cycle bubble on load-use hazards.

---
 rtl/instr_decode_if.sv | 57 +++++
 rtl/instr_decode.sv | 183 ++++++++++++++++++
 tb/tb_instr_decode.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// -----------------------------------------------------------------------------
// instr_decode_if
//   Bundles the instruction-decode stage's input handshake, output handshake
//   and decoded output bus into one interface.
//
//   slave  : the decode stage's view. It receives flush, in_valid, instr, pc
//            and out_ready. It drives in_ready, out_valid and the decoded
//            fields.
//   master : the surrounding pipeline's or testbench's view. Its directions
//            are the mirror image of slave.
//
//   Signals
//     flush      sync kill of the output register
//     in_valid   instr/pc valid           in_ready   stage accepts this cycle
//     instr[32]  instruction word         pc[32]     address of instr
//     out_valid  decoded outputs valid    out_ready  downstream accepts
//     pc_out[32] registered pc
//     readReg1/readReg2/writeReg/shamt [5], funct [6], imm_ext [32]
//     reg_write mem_read mem_write alu_src branch jump illegal : control bits
// -----------------------------------------------------------------------------
interface instr_decode_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] pc_out;
    logic [4:0]  readReg1;
    logic [4:0]  readReg2;
    logic [4:0]  writeReg;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        illegal;

    modport slave (
        input  flush, in_valid, instr, pc, out_ready,
        output in_ready, out_valid, pc_out, readReg1, readReg2, writeReg,
               shamt, funct, imm_ext, reg_write, mem_read, mem_write,
               alu_src, branch, jump, illegal
    );

    modport master (
        output flush, in_valid, instr, pc, out_ready,
        input  in_ready, out_valid, pc_out, readReg1, readReg2, writeReg,
               shamt, funct, imm_ext, reg_write, mem_read, mem_write,
               alu_src, branch, jump, illegal
    );
endinterface

// File: rtl/instr_decode.sv
// -----------------------------------------------------------------------------
// instr_decode
//   Single-stage pipelined decoder for the 32-bit MIPS-style core. The stage
//   accepts one instruction per in_valid/in_ready handshake. It splits the
//   instruction into register addresses, the extended immediate and datapath
//   control bits. All of these sit in one output register that is handed
//   downstream with an out_valid/out_ready handshake.
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset. It clears the whole output
//             register.
//     bus   : instr_decode_if.slave. Its members are the handshake, the
//             instruction/pc inputs and the decoded outputs.
//
//   Build option
//     DECODE_HAZARD_EN : when this macro is defined, the stage refuses an
//             instruction that reads the destination of a lw still held in
//             the output register. That inserts exactly one bubble. When the
//             macro is undefined, the hazard term is tied low.
// -----------------------------------------------------------------------------
module instr_decode (
    input  logic           clk,
    input  logic           rst_n,
    instr_decode_if.slave  bus
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Contents of the output pipeline register.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        logic        branch;
        logic        jump;
        logic        illegal;
    } dec_t;

    logic [5:0] opcode;
    dec_t       dec_c;               // combinational decode of bus.instr
    dec_t       dec_d, dec_q;
    logic       valid_d, valid_q;
    logic       hazard;
    logic       in_ready;
    logic       accept;

    assign opcode = bus.instr[31:26];

    // ---------------------------------------------------------------- decode
    always_comb begin
        dec_c       = '0;
        dec_c.pc    = bus.pc;
        dec_c.rs    = bus.instr[25:21];
        dec_c.rt    = bus.instr[20:16];
        dec_c.shamt = bus.instr[10:6];
        dec_c.funct = bus.instr[5:0];
        // Sign extension is the common case. andi/ori and j override it below.
        dec_c.imm   = {{16{bus.instr[15]}}, bus.instr[15:0]};
        case (opcode)
            OP_RTYPE: begin
                dec_c.wr        = bus.instr[15:11];
                dec_c.reg_write = 1'b1;
            end
            OP_ADDI: begin
                dec_c.wr        = bus.instr[20:16];
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                dec_c.wr        = bus.instr[20:16];
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.imm       = {16'h0000, bus.instr[15:0]};
            end
            OP_LW: begin
                dec_c.wr        = bus.instr[20:16];
                dec_c.alu_src   = 1'b1;
                dec_c.mem_read  = 1'b1;
                dec_c.reg_write = 1'b1;
            end
            OP_SW: begin
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
            end
            OP_BEQ: begin
                dec_c.branch    = 1'b1;
            end
            OP_J: begin
                dec_c.jump      = 1'b1;
                dec_c.imm       = {6'b0, bus.instr[25:0]};
            end
            default: begin
                dec_c.illegal   = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------- hazard
`ifdef DECODE_HAZARD_EN
    // The rt field is a source only for R-type, sw and beq. For the other
    // opcodes, rt is a destination or unused.
    logic reads_rt;
    always_comb begin
        reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    end

    // A held lw whose result is not yet available. r0 never creates a
    // dependency.
    assign hazard = valid_q && dec_q.mem_read && (dec_q.wr != 5'd0) && bus.in_valid &&
                    ((bus.instr[25:21] == dec_q.wr) ||
                     (reads_rt && (bus.instr[20:16] == dec_q.wr)));
`else
    assign hazard = 1'b0;
`endif

    // ------------------------------------------------------------- handshake
    assign in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;
    assign accept   = bus.in_valid && in_ready;

    // Priority: flush > accept > drain.
    // A flush that coincides with an output handshake still empties the
    // register, and that is the intended result.
    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        if (bus.flush) begin
            valid_d = 1'b0;
            dec_d   = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            dec_d   = dec_c;
        end else if (bus.out_ready) begin
            // Consumed with nothing behind it: a bubble. The fields are
            // left as they were because out_valid=0 marks them stale.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.pc_out    = dec_q.pc;
    assign bus.readReg1  = dec_q.rs;
    assign bus.readReg2  = dec_q.rt;
    assign bus.writeReg  = dec_q.wr;
    assign bus.shamt     = dec_q.shamt;
    assign bus.funct     = dec_q.funct;
    assign bus.imm_ext   = dec_q.imm;
    assign bus.reg_write = dec_q.reg_write;
    assign bus.mem_read  = dec_q.mem_read;
    assign bus.mem_write = dec_q.mem_write;
    assign bus.alu_src   = dec_q.alu_src;
    assign bus.branch    = dec_q.branch;
    assign bus.jump      = dec_q.jump;
    assign bus.illegal   = dec_q.illegal;

endmodule

// File: tb/tb_instr_decode.sv
module tb_instr_decode;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    instr_decode_if bus ();

    instr_decode dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------- reference model
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs, rt, wr, shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        bit          imm_known;
        logic [6:0]  ctl;   // {reg_write,mem_read,mem_write,alu_src,branch,jump,illegal}
        logic        is_lw;
    } exp_t;

    // Each output is derived from the set of opcodes that assert it.
    function automatic exp_t model(logic [31:0] w, logic [31:0] p);
        exp_t        e;
        logic [5:0]  op;
        bit          legal, writes, zext;
        op        = w[31:26];
        legal     = op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
        writes    = op inside {6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23};
        zext      = op inside {6'h0C, 6'h0D};
        e.pc      = p;
        e.rs      = w[25:21];
        e.rt      = w[20:16];
        e.shamt   = w[10:6];
        e.funct   = w[5:0];
        e.wr      = !writes ? 5'd0 : (op == 6'h00 ? w[15:11] : w[20:16]);
        e.imm_known = op inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02};
        if (op == 6'h02)  e.imm = {6'b0, w[25:0]};
        else if (zext)    e.imm = {16'h0, w[15:0]};
        else              e.imm = {{16{w[15]}}, w[15:0]};
        e.ctl = {writes, op == 6'h23, op == 6'h2B,
                 op inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B},
                 op == 6'h04, op == 6'h02, !legal};
        e.is_lw = (op == 6'h23);
        return e;
    endfunction

    logic m_valid;
    exp_t m_out;

    function automatic bit m_hazard();
`ifdef DECODE_HAZARD_EN
        logic [5:0] op;
        bit         rt_src;
        op     = bus.instr[31:26];
        rt_src = op inside {6'h00, 6'h2B, 6'h04};
        return m_valid && m_out.is_lw && m_out.wr != 0 && bus.in_valid &&
               (bus.instr[25:21] == m_out.wr || (rt_src && bus.instr[20:16] == m_out.wr));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit m_in_ready();
        return (!m_valid || bus.out_ready) && !m_hazard() && !bus.flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
        end else if (bus.in_valid && m_in_ready()) begin
            m_valid <= 1'b1;
            m_out   <= model(bus.instr, bus.pc);
        end else if (bus.out_ready) begin
            m_valid <= 1'b0;
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] ctl_vec();
        return {bus.reg_write, bus.mem_read, bus.mem_write, bus.alu_src,
                bus.branch, bus.jump, bus.illegal};
    endfunction

    // Continuous compare, away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, m_in_ready()});
            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("pc_out",   bus.pc_out, m_out.pc);
                chk("readReg1", {27'b0, bus.readReg1}, {27'b0, m_out.rs});
                chk("readReg2", {27'b0, bus.readReg2}, {27'b0, m_out.rt});
                chk("writeReg", {27'b0, bus.writeReg}, {27'b0, m_out.wr});
                chk("shamt",    {27'b0, bus.shamt},    {27'b0, m_out.shamt});
                chk("funct",    {26'b0, bus.funct},    {26'b0, m_out.funct});
                chk("ctl",      {25'b0, ctl_vec()},    {25'b0, m_out.ctl});
                if (m_out.imm_known) chk("imm_ext", bus.imm_ext, m_out.imm);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(logic [31:0] w, logic [31:0] p);
        bus.in_valid = 1'b1;
        bus.instr    = w;
        bus.pc       = p;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_ctl"}, {25'b0, ctl_vec()}, 32'd0);
        chk({tag, "_regs"}, {12'b0, bus.readReg1, bus.readReg2, bus.writeReg, bus.shamt},
            32'd0);
        chk({tag, "_funct"}, {26'b0, bus.funct}, 32'd0);
        chk({tag, "_imm"}, bus.imm_ext, 32'd0);
        chk({tag, "_pc"}, bus.pc_out, 32'd0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [9];
        logic [31:0] w;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
        w = $urandom;
        w[31:26] = ops[$urandom_range(0, 8)];
        if ($urandom_range(0, 3) == 0) w[31:26] = 6'($urandom);
        // Small register numbers make load-use dependencies frequent.
        w[25:21] = 5'($urandom_range(0, 3));
        w[20:16] = 5'($urandom_range(0, 3));
        w[15:11] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    logic ov [3];
    logic acc;

    initial begin
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.instr     = '0;
        bus.pc        = '0;

        // Reset state.
        repeat (3) tick();
        chk_all_zero("reset");
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", {31'b0, bus.in_ready}, 32'd1);
        tick();

        // R-type: add $3,$1,$2
        send1(32'h00221820, 32'h100);
        chk("rtype_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("rtype_rr1", {27'b0, bus.readReg1}, 32'd1);
        chk("rtype_rr2", {27'b0, bus.readReg2}, 32'd2);
        chk("rtype_wr",  {27'b0, bus.writeReg}, 32'd3);
        chk("rtype_rw_as", {30'b0, bus.reg_write, bus.alu_src}, 32'b10);
        chk("rtype_funct", {26'b0, bus.funct}, 32'h20);
        chk("rtype_pc", bus.pc_out, 32'h100);

        // Immediate extension.
        send1(32'h2005FFFF, 32'h104);
        chk("addi_imm", bus.imm_ext, 32'hFFFFFFFF);
        chk("addi_wr", {27'b0, bus.writeReg}, 32'd5);
        send1(32'h34068000, 32'h108);
        chk("ori_imm", bus.imm_ext, 32'h00008000);

        // Illegal opcode.
        send1(32'hFC000000, 32'h10C);
        chk("illegal_ctl", {25'b0, ctl_vec()}, 32'h1);
        chk("illegal_wr", {27'b0, bus.writeReg}, 32'd0);

        // Load-use pair: lw $4 then add $5,$4,$2.
        bus.in_valid = 1'b1; bus.instr = 32'h8C240000; bus.pc = 32'h200;
        tick();
        ov[0] = bus.out_valid;
        bus.instr = 32'h00822820; bus.pc = 32'h204;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            acc = bus.in_ready && bus.in_valid;
            tick();
            ov[k] = bus.out_valid;
            if (acc) bus.in_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
`ifdef DECODE_HAZARD_EN
        chk("loaduse_seq", {29'b0, ov[0], ov[1], ov[2]}, 32'b101);
`else
        chk("loaduse_seq", {29'b0, ov[0], ov[1], ov[2]}, 32'b110);
`endif
        tick();

        // Backpressure: sw held while a new addi waits.
        send1(32'hAC450008, 32'h300);
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.instr = 32'h20A6FFFE; bus.pc = 32'h304;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("bp_pc", bus.pc_out, 32'h300);
            chk("bp_sw", {25'b0, ctl_vec()}, 32'b0011000);
            chk("bp_imm", bus.imm_ext, 32'h8);
        end
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("bp_drain_pc", bus.pc_out, 32'h304);
        chk("bp_drain_imm", bus.imm_ext, 32'hFFFFFFFE);
        chk("bp_drain_wr", {27'b0, bus.writeReg}, 32'd6);
        tick();
        chk("bp_empty", {31'b0, bus.out_valid}, 32'd0);

        // Flush while an instruction is held.
        bus.out_ready = 1'b0;
        send1(32'h00221820, 32'h400);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);

        // Asynchronous reset mid-stall.
        send1(32'h8C240010, 32'h500);
        chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 24) == 0);
            bus.instr     = rand_instr();
            bus.pc        = $urandom;
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
